// File: rtl/pulpino_boot_pkg.sv
// Shared types for the PULPino boot sequencer: FSM states,
// reset-cause codes and a small sizing helper.
package pulpino_boot_pkg;

    localparam int unsigned SEQ_STATE_W = 3;

    typedef enum logic [SEQ_STATE_W-1:0] {
        S_HOLD      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_PERIPH    = 3'd2,
        S_CORE      = 3'd3,
        S_FETCH     = 3'd4,
        S_RUN       = 3'd5
    } seq_state_e;

    typedef enum logic [2:0] {
        CAUSE_POR  = 3'd0,
        CAUSE_BTN  = 3'd1,
        CAUSE_LOCK = 3'd2,
        CAUSE_SW   = 3'd3,
        CAUSE_WDT  = 3'd4
    } rst_cause_e;

    function automatic int unsigned max3(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pulpino_boot_seq_btn.sv
// Reset pushbutton synchroniser and debouncer; the output is
// the debounced "pressed" level of the active-low button.
module boot_btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_resetn_i,
    output logic btn_pressed_o
);
    import pulpino_boot_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // level_q holds the debounced pin value, 1 = released
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_resetn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_pressed_o = ~level_q;

endmodule

// File: rtl/pulpino_boot_seq.sv
// Boot sequencer: lock/button/software reset to ordered release of
// peripheral reset, core reset and fetch_enable. SEQ_WDT_EN adds a watchdog.
module pulpino_boot_seq
    import pulpino_boot_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES    = 500000,
    parameter int unsigned PERIPH_HOLD_CYCLES = 16,
    parameter int unsigned CORE_HOLD_CYCLES   = 16,
    parameter int unsigned FETCH_DELAY_CYCLES = 8,
    parameter int unsigned WDT_CYCLES         = 50000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   locked_i,
    input  logic                   btn_resetn_i,
    input  logic                   sw_reset_req_i,
    input  logic                   wdt_kick_i,
    output logic                   periph_rst_n_o,
    output logic                   core_rst_n_o,
    output logic                   fetch_enable_o,
    output logic [SEQ_STATE_W-1:0] seq_state_o,
    output logic [2:0]             reset_cause_o
);

    if (DEBOUNCE_CYCLES == 0 || PERIPH_HOLD_CYCLES == 0 ||
        CORE_HOLD_CYCLES == 0 || FETCH_DELAY_CYCLES == 0 ||
        WDT_CYCLES == 0) begin : g_param_check
        $fatal(1, "pulpino_boot_seq: *_CYCLES must be >= 1");
    end

    localparam int unsigned CNT_W = $clog2(max3(
        PERIPH_HOLD_CYCLES, CORE_HOLD_CYCLES, FETCH_DELAY_CYCLES) + 1);
    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PERIPH_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CORE_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] F_LAST = CNT_W'(FETCH_DELAY_CYCLES - 1);

    seq_state_e       state_q;
    seq_state_e       state_d;
    rst_cause_e       cause_q;
    rst_cause_e       cause_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             periph_q;
    logic             periph_d;
    logic             core_q;
    logic             core_d;
    logic             fetch_q;
    logic             fetch_d;
    logic             btn_pressed;
    logic             wdt_fire;
    logic             active;

    boot_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk          (clk),
        .rst          (rst),
        .btn_resetn_i (btn_resetn_i),
        .btn_pressed_o(btn_pressed)
    );

`ifdef SEQ_WDT_EN
    localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_q;
    logic [WDT_W-1:0] wdt_d;

    assign wdt_fire = (state_q == S_RUN) && !wdt_kick_i &&
                      (wdt_q == WDT_LAST);

    always_comb begin
        wdt_d = '0;
        if (state_d == S_RUN && !wdt_kick_i) begin
            wdt_d = wdt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end
`else
    logic unused_wdt;
    assign unused_wdt = wdt_kick_i ^ (WDT_CYCLES == 0);
    assign wdt_fire   = 1'b0;
`endif

    assign active = (state_q == S_PERIPH) || (state_q == S_CORE) ||
                    (state_q == S_FETCH)  || (state_q == S_RUN);

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_HOLD: begin
                cnt_d = '0;
                if (!btn_pressed) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                cnt_d = '0;
                if (btn_pressed)   state_d = S_HOLD;
                else if (locked_i) state_d = S_PERIPH;
            end
            S_PERIPH: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == P_LAST) begin
                    state_d = S_CORE;
                    cnt_d   = '0;
                end
            end
            S_CORE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_LAST) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == F_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: cnt_d = '0;
            default: begin
                state_d = S_HOLD;
                cnt_d   = '0;
            end
        endcase
        // abort cause priority: lock, button, software, watchdog
        if (active && (!locked_i || btn_pressed ||
                       sw_reset_req_i || wdt_fire)) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            if (!locked_i)           cause_d = CAUSE_LOCK;
            else if (btn_pressed)    cause_d = CAUSE_BTN;
            else if (sw_reset_req_i) cause_d = CAUSE_SW;
            else                     cause_d = CAUSE_WDT;
        end
        periph_d = (state_d == S_CORE) || (state_d == S_FETCH) ||
                   (state_d == S_RUN);
        core_d   = (state_d == S_FETCH) || (state_d == S_RUN);
        fetch_d  = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_HOLD;
            cause_q  <= CAUSE_POR;
            cnt_q    <= '0;
            periph_q <= 1'b0;
            core_q   <= 1'b0;
            fetch_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            cnt_q    <= cnt_d;
            periph_q <= periph_d;
            core_q   <= core_d;
            fetch_q  <= fetch_d;
        end
    end

    assign periph_rst_n_o = periph_q;
    assign core_rst_n_o   = core_q;
    assign fetch_enable_o = fetch_q;
    assign seq_state_o    = state_q;
    assign reset_cause_o  = cause_q;

endmodule
